// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch and data access.
// Registered req/ack memory handshake, per-port valid pulses, timeout abort, saturating conflict counter.
module unified_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              err,
    output logic [15:0]       conflict_count
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state, state_next;
    logic              dm_any;
    logic              tie;
    logic              grant_dm;
    logic              do_grant;
    logic              do_finish;
    logic              timed_out;
    logic              cur_dm;
    logic              last_grant_dm;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  wait_cnt_inc;
    logic [15:0]       conflict_cnt;

    assign dm_any       = dm_read | dm_write;
    assign tie          = if_req & dm_any;
    // On a tie the port that did not win last time gets the memory.
    assign grant_dm     = dm_any & (~if_req | ~last_grant_dm);
    assign wait_cnt_inc = wait_cnt + 1'b1;

    assign stall          = (if_req & ~if_valid) | (dm_any & ~dm_valid);
    assign conflict_count = conflict_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        do_finish  = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (if_req | dm_any) begin
                    do_grant   = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    do_finish  = 1'b1;
                    state_next = RESP;
                end else if (wait_cnt_inc == TIMEOUT_CNT) begin
                    do_finish  = 1'b1;
                    timed_out  = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            cur_dm        <= 1'b0;
            last_grant_dm <= 1'b0;
            wait_cnt      <= '0;
            conflict_cnt  <= '0;
            err           <= 1'b0;
            if_valid      <= 1'b0;
            dm_valid      <= 1'b0;
            if_rdata      <= '0;
            dm_rdata      <= '0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;

            // Grant: latch the winning port's request into the memory-side registers.
            if (do_grant) begin
                mem_req       <= 1'b1;
                mem_we        <= grant_dm & dm_write;
                mem_addr      <= grant_dm ? dm_addr : if_addr;
                mem_wdata     <= grant_dm ? dm_wdata : mem_wdata;
                cur_dm        <= grant_dm;
                last_grant_dm <= grant_dm;
                wait_cnt      <= '0;
                if (tie && (conflict_cnt != 16'hFFFF)) begin
                    conflict_cnt <= conflict_cnt + 16'd1;
                end
            end

            // Completion: ack or timeout; aborted reads return zero.
            if (state == BUSY) begin
                if (do_finish) begin
                    mem_req <= 1'b0;
                    if (timed_out) begin
                        err <= 1'b1;
                    end
                    if (!mem_we) begin
                        if (cur_dm) begin
                            dm_rdata <= timed_out ? '0 : mem_rdata;
                        end else begin
                            if_rdata <= timed_out ? '0 : mem_rdata;
                        end
                    end
                    if (cur_dm) begin
                        dm_valid <= 1'b1;
                    end else begin
                        if_valid <= 1'b1;
                    end
                end else begin
                    wait_cnt <= wait_cnt_inc;
                end
            end
        end
    end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-port unified memory between the pipeline's instruction-fetch port (PC / IF stage) and data port (MEM stage load/store). The block runs a req/ack handshake to the memory, arbitrates round-robin when both ports request, returns read data through registered per-port valid pulses, and drives a pipeline stall. It also aborts hung accesses after a timeout and counts arbitration conflicts for the performance unit.

## Interface
Parameters:
- ADDR_W, 32, memory address width (IF and DM share the address space)
- DATA_W, 32, data width
- TIMEOUT, 255, maximum wait cycles for mem_ack before abort (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_valid
- if_addr  in  ADDR_W  fetch address; stable while if_req high
- if_rdata  out  DATA_W  fetched word, registered
- if_valid  out  1  one-cycle pulse: if_rdata valid
- dm_read  in  1  load request; held until dm_valid
- dm_write  in  1  store request; held until dm_valid
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data, registered
- dm_valid  out  1  one-cycle pulse: load data valid or store done
- mem_req  out  1  memory request, registered
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  memory completion; may assert in first mem_req cycle
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- stall  out  1  pipeline hold, combinational
- err  out  1  sticky timeout flag
- conflict_count  out  16  saturating count of conflict grants

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if dm_read|dm_write or if_req is high, grant one port and latch its address, we and wdata into mem_* regs. Set mem_req=1 and go to BUSY. With no request, stay in IDLE.
- Arbitration: a single request is granted directly. When both ports request, grant the port that is not last_grant (round-robin). last_grant updates on every grant.
- On a tie grant, conflict_count increments and saturates at 0xFFFF.
- dm_read and dm_write both high: treated as a write (mem_we=1). A store-done dm_valid leaves dm_rdata unchanged.
- BUSY: hold mem_* stable.
  - mem_ack=1: drop mem_req. For a read, capture mem_rdata into the granted port's rdata register. Go to RESP.
  - Wait counter reaches TIMEOUT with no ack: drop mem_req, set err, load 0 into the granted port's rdata register (reads), go to RESP.
- RESP: pulse the granted port's valid for exactly one cycle. No new grant is made in this state. Return to IDLE; the requester may deassert or change its request in the RESP cycle.
- stall = (if_req & ~if_valid) | ((dm_read|dm_write) & ~dm_valid).
- err clears only on reset.

## Timing
- Reset (rst low, asynchronous) forces:
  - state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0
  - if_valid=0, dm_valid=0, if_rdata=0, dm_rdata=0
  - err=0, conflict_count=0, wait counter=0
  - last_grant=IF, so the first tie goes to DM
- Reset mid-access drops mem_req immediately and produces no valid pulse.
- Zero-wait memory: request seen in IDLE at cycle 0. mem_req=1 in cycle 1, ack in cycle 1, valid in cycle 2, IDLE in cycle 3. This gives 3 cycles per access.
- N-cycle ack (ack in the Nth mem_req cycle): valid in cycle N+1.
- The wait counter clears on each grant and counts BUSY cycles. Abort happens after the TIMEOUT-th BUSY cycle without ack.
- mem_ack outside BUSY is ignored.
- Back-to-back: a request held through RESP is regranted in the following IDLE cycle. Per-port throughput is one access per 3 cycles at zero-wait.
- stall is high in cycle 0 of a request through the cycle before valid, and low in the valid cycle.

## Test plan
- Lone fetch: if_req=1, if_addr=0x40, ack same cycle with mem_rdata=0xDEADBEEF -> mem_req cycle 1 with mem_we=0 and mem_addr=0x40; if_valid cycle 2 with if_rdata=0xDEADBEEF; stall high cycles 0–1, low cycle 2.
- Tie after reset: if_req and dm_read both 1, zero-wait memory -> DM granted first, then IF. dm_valid cycle 2, if_valid cycle 5. conflict_count reads 1 after the first grant and 2 after the second; both ports still request at the second grant.
- Store with wait states: dm_write=1, addr 0x100, wdata 0x12345678, ack in 3rd mem_req cycle -> mem_we=1 with mem_* stable for 3 cycles; dm_valid cycle 4; dm_rdata unchanged.
- Timeout: TIMEOUT=4, dm_read, no ack -> mem_req high 4 cycles then low; err=1; dm_valid pulses with dm_rdata=0; err stays 1 through later successful accesses.
- Reset mid-BUSY: rst low during a fetch's 2nd wait cycle -> mem_req=0 immediately, no if_valid, all outputs at reset values. After release, a new fetch completes normally.
- Saturation: preload conflict_count by 65,540 alternating tie grants -> holds 0xFFFF with no wrap.
